// File: rtl/traffic_light_controller_n.sv
// N-way round-robin traffic light controller with latched sensor requests,
// minimum green, yellow and all-red clearance, and registered Moore lamp outputs.
module traffic_light_controller_n #(
    parameter int N_DIR        = 4,
    parameter int GREEN_TICKS  = 6,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    localparam int IW    = (N_DIR > 1) ? $clog2(N_DIR) : 1,
    localparam int MAX_T = (GREEN_TICKS > YELLOW_TICKS)
                         ? ((GREEN_TICKS > ALLRED_TICKS) ? GREEN_TICKS : ALLRED_TICKS)
                         : ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS),
    localparam int TW    = $clog2(MAX_T) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DIR-1:0] sensor,
    output logic [N_DIR-1:0] green,
    output logic [N_DIR-1:0] yellow,
    output logic [N_DIR-1:0] red,
    output logic [IW-1:0]    active_dir,
    output logic [1:0]       state_test
);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_t;

    localparam logic [TW-1:0] G_LAST = TW'(GREEN_TICKS - 1);
    localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_TICKS - 1);
    localparam logic [TW-1:0] A_LAST = TW'(ALLRED_TICKS - 1);

    phase_t             r_phase;
    logic [IW-1:0]      r_active;
    logic [TW-1:0]      r_timer;
    logic [N_DIR-1:0]   r_req;
    logic [N_DIR-1:0]   r_green;
    logic [N_DIR-1:0]   r_yellow;
    logic [N_DIR-1:0]   r_red;

    phase_t             w_phase_next;
    logic [IW-1:0]      w_dir_next;
    logic [TW-1:0]      w_timer_next;
    logic [N_DIR-1:0]   w_req_next;
    logic [N_DIR-1:0]   w_active_oh;
    logic [N_DIR-1:0]   w_next_oh;
    logic [N_DIR-1:0]   w_req_set;
    logic               w_others;
    logic [IW-1:0]      w_rr_dir;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIR; gi++) begin : g_dir
            assign w_active_oh[gi] = (r_active == IW'(gi));
            assign w_next_oh[gi]   = (w_dir_next == IW'(gi));
            // The owner's own sensor is meaningless while it is already green.
            assign w_req_set[gi]   = sensor[gi] & ~((r_phase == PH_GREEN) & w_active_oh[gi]);
        end
    endgenerate

    assign w_others = |(r_req & ~w_active_oh);

    // Round-robin pick: first pending request after the current owner, owner last.
    always_comb begin
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        w_rr_dir = r_active;
        for (int k = 1; k <= N_DIR; k++) begin
            idx = (int'(r_active) + k) % N_DIR;
            if (!found && r_req[idx]) begin
                found    = 1'b1;
                w_rr_dir = IW'(idx);
            end
        end
    end

    always_comb begin
        w_phase_next = r_phase;
        w_dir_next   = r_active;
        w_timer_next = r_timer;
        w_req_next   = r_req | w_req_set;
        case (r_phase)
            PH_GREEN: begin
                if (r_timer == G_LAST && w_others) begin
                    w_phase_next = PH_YELLOW;
                    w_timer_next = '0;
                end else if (r_timer != G_LAST) begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            PH_YELLOW: begin
                if (r_timer == Y_LAST) begin
                    w_phase_next = PH_ALLRED;
                    w_timer_next = '0;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            PH_ALLRED: begin
                if (r_timer == A_LAST) begin
                    w_phase_next         = PH_GREEN;
                    w_timer_next         = '0;
                    w_dir_next           = w_rr_dir;
                    // Clearing after the set merge lets clear win on the same edge.
                    w_req_next[w_rr_dir] = 1'b0;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            default: begin
                w_phase_next = PH_GREEN;
                w_timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_GREEN;
            r_active <= '0;
            r_timer  <= '0;
            r_req    <= '0;
            r_green  <= N_DIR'(1);
            r_yellow <= '0;
            r_red    <= ~N_DIR'(1);
        end else begin
            r_phase  <= w_phase_next;
            r_active <= w_dir_next;
            r_timer  <= w_timer_next;
            r_req    <= w_req_next;
            r_green  <= (w_phase_next == PH_GREEN)  ? w_next_oh : '0;
            r_yellow <= (w_phase_next == PH_YELLOW) ? w_next_oh : '0;
            r_red    <= (w_phase_next == PH_ALLRED) ? '1 : ~w_next_oh;
        end
    end

    assign green      = r_green;
    assign yellow     = r_yellow;
    assign red        = r_red;
    assign active_dir = r_active;
    assign state_test = r_phase;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Scoreboard bench for traffic_light_controller_n: a phase/age reference model
// pushes expected lamps per edge, a monitor pops and compares after each edge.
module tb_traffic_light_controller_n;

    localparam int N = 4;
    localparam int G = 6;
    localparam int Y = 2;
    localparam int A = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sensor;
    logic [N-1:0] green, yellow, red;
    logic [1:0]   active_dir;
    logic [1:0]   state_test;

    traffic_light_controller_n #(
        .N_DIR(N), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A)
    ) dut (
        .clk(clk), .rst(rst), .sensor(sensor),
        .green(green), .yellow(yellow), .red(red),
        .active_dir(active_dir), .state_test(state_test)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] g;
        logic [N-1:0] y;
        logic [N-1:0] r;
        logic [1:0]   dir;
        logic [1:0]   st;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   running = 1'b0;

    // Reference model: phase (0 G,1 Y,2 AR), owner, cycles spent in phase, pending set.
    int m_phase, m_dir, m_age;
    bit m_pend[N];

    task automatic model_step(input bit r_in, input logic [N-1:0] s);
        bit newp[N];
        bit others;
        int nd, c;
        if (r_in) begin
            m_phase = 0; m_dir = 0; m_age = 0;
            for (int j = 0; j < N; j++) m_pend[j] = 1'b0;
            return;
        end
        others = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (j != m_dir && m_pend[j]) others = 1'b1;
            newp[j] = m_pend[j] | (s[j] && !(m_phase == 0 && j == m_dir));
        end
        case (m_phase)
            0: if (m_age >= G - 1 && others) begin m_phase = 1; m_age = 0; end
               else m_age++;
            1: if (m_age == Y - 1) begin m_phase = 2; m_age = 0; end
               else m_age++;
            default: if (m_age == A - 1) begin
                nd = m_dir;
                for (int k = 1; k <= N; k++) begin
                    c = (m_dir + k) % N;
                    if (m_pend[c]) begin nd = c; break; end
                end
                m_phase = 0; m_age = 0; m_dir = nd;
                newp[nd] = 1'b0;
            end else m_age++;
        endcase
        for (int j = 0; j < N; j++) m_pend[j] = newp[j];
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        logic [N-1:0] one;
        one   = N'(1);
        e.g   = (m_phase == 0) ? (one << m_dir) : '0;
        e.y   = (m_phase == 1) ? (one << m_dir) : '0;
        e.r   = ~(e.g | e.y);
        e.dir = 2'(m_dir);
        e.st  = 2'(m_phase);
        return e;
    endfunction

    // Drive inputs for the coming edge, advance the model, queue the expectation.
    task automatic cycle(input bit r_in, input logic [N-1:0] s);
        rst    = r_in;
        sensor = s;
        model_step(r_in, s);
        sb.push_back(model_expect());
        @(negedge clk);
    endtask

    task automatic timeout(input string what);
        n_fail++;
        $display("[TB] FAIL timeout %s: model never reached the target state", what);
    endtask

    exp_t       mon_e;
    logic [1:0] last_st = 2'd3;
    always @(posedge clk) begin
        #1;
        if (running) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("[TB] FAIL scoreboard: got output with no expected entry");
            end else begin
                mon_e = sb.pop_front();
                n_tests++;
                if (green !== mon_e.g || yellow !== mon_e.y || red !== mon_e.r) begin
                    n_fail++;
                    $display("[TB] FAIL lamps t=%0t: got g=%b y=%b r=%b, expected g=%b y=%b r=%b",
                             $time, green, yellow, red, mon_e.g, mon_e.y, mon_e.r);
                end
                n_tests++;
                if (active_dir !== mon_e.dir) begin
                    n_fail++;
                    $display("[TB] FAIL active_dir t=%0t: got %0d, expected %0d",
                             $time, active_dir, mon_e.dir);
                end
                n_tests++;
                if (state_test !== mon_e.st) begin
                    n_fail++;
                    $display("[TB] FAIL state_test t=%0t: got %0d, expected %0d",
                             $time, state_test, mon_e.st);
                end
                if (state_test !== last_st)
                    $display("[TB] t=%0t phase=%0d dir=%0d g=%b y=%b r=%b",
                             $time, state_test, active_dir, green, yellow, red);
                last_st = state_test;
            end
        end
    end

    initial begin
        int i;
        logic [N-1:0] s;
        running = 1'b1;

        // Reset then idle: dir 0 holds green.
        cycle(1'b1, '0);
        cycle(1'b1, '0);
        repeat (50) cycle(1'b0, '0);

        // Single pulse on sensor[2] with the timer saturated.
        cycle(1'b0, 4'b0100);
        repeat (12) cycle(1'b0, '0);

        // Bring dir 1 to green, then hold sensor[3] from its first green cycle.
        cycle(1'b0, 4'b0010);
        for (i = 0; i < 40 && !(m_phase == 0 && m_dir == 1); i++) cycle(1'b0, '0);
        if (!(m_phase == 0 && m_dir == 1)) timeout("dir1 green");
        for (i = 0; i < 40 && !(m_phase == 0 && m_dir == 3); i++) cycle(1'b0, 4'b1000);
        if (!(m_phase == 0 && m_dir == 3)) timeout("dir3 green");
        repeat (3) cycle(1'b0, '0);

        // Round-robin wrap: dir 1 green, then 0 and 3 together -> 3 then 0.
        cycle(1'b0, 4'b0010);
        for (i = 0; i < 40 && !(m_phase == 0 && m_dir == 1); i++) cycle(1'b0, '0);
        if (!(m_phase == 0 && m_dir == 1)) timeout("dir1 green again");
        repeat (8) cycle(1'b0, '0);
        cycle(1'b0, 4'b1001);
        repeat (30) cycle(1'b0, '0);

        // Own sensor ignored in green, latched in yellow.
        repeat (10) cycle(1'b0, 4'b0001);
        cycle(1'b0, 4'b0100);
        for (i = 0; i < 20 && m_phase != 1; i++) cycle(1'b0, '0);
        if (m_phase != 1) timeout("yellow");
        cycle(1'b0, 4'b0001);
        repeat (30) cycle(1'b0, '0);

        // Reset during the second yellow cycle.
        repeat (8) cycle(1'b0, '0);
        cycle(1'b0, 4'b0010);
        for (i = 0; i < 20 && !(m_phase == 1 && m_age == 1); i++) cycle(1'b0, '0);
        if (!(m_phase == 1 && m_age == 1)) timeout("second yellow cycle");
        cycle(1'b1, 4'b1111);
        repeat (10) cycle(1'b0, '0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            s = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            cycle(($urandom_range(0, 199) == 0), s);
        end

        running = 1'b0;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
